// File: rtl/nibble_serial_alu_ctrl.sv
// nibble_serial_alu_ctrl
// 16-bit add/subtract computed through a single 4-bit slice, one nibble per
// cycle, least-significant nibble first. A three-state controller (IDLE, RUN,
// DONE) sequences the slice and emits a one-cycle done pulse when result and
// flags are valid.
//
// Optional build macro:
//   SAT_EN - when defined, a signed overflow on the final nibble saturates
//            the result to 16'h7FFF or 16'h8000 (sign taken from operand A).
//            When undefined the result wraps and no saturation logic exists.

module nibble_serial_alu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        overflow,
  output logic        zero
);

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Sequencing state
  logic [1:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;

  // Operands captured at the accepting edge; the operation only ever looks
  // at these copies, so the live inputs may change freely while busy.
  logic [15:0] a_lat_q, a_lat_d;
  logic [15:0] b_lat_q, b_lat_d;
  logic        op_q, op_d;

  // Carry rippling between successive nibbles
  logic        chain_c_q, chain_c_d;

  // Architectural outputs
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;

  // Slice datapath
  logic [3:0]  nib_base;
  logic [3:0]  a_nib;
  logic [3:0]  b_raw;
  logic [3:0]  b_nib;
  logic [3:0]  low_sum;
  logic        c_into_msb;
  logic [1:0]  msb_sum;
  logic [3:0]  slice_sum;
  logic        slice_cout;
  logic        slice_ovf;
  logic [15:0] final_wrap;
  logic [15:0] final_res;

  // Bit offset of the nibble currently being processed
  assign nib_base = {cnt_q, 2'b00};

  // Operand nibble selection; subtraction is a + ~b + 1, where the +1 comes
  // from the chain carry preloaded with op at the accepting edge.
  always_comb begin
    a_nib = a_lat_q[nib_base +: 4];
    b_raw = b_lat_q[nib_base +: 4];
    b_nib = op_q ? ~b_raw : b_raw;
  end

  // The slice is split at bit 3 so the carry into its top bit is visible;
  // on the last nibble that is the carry into bit 15 needed for overflow.
  always_comb begin
    low_sum    = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, chain_c_q};
    c_into_msb = low_sum[3];
    msb_sum    = {1'b0, a_nib[3]} + {1'b0, b_nib[3]} + {1'b0, c_into_msb};
    slice_sum  = {msb_sum[0], low_sum[2:0]};
    slice_cout = msb_sum[1];
    slice_ovf  = c_into_msb ^ slice_cout;
  end

  // Assemble the full 16-bit value on the final nibble and optionally clamp
  always_comb begin
    final_wrap = {slice_sum, result_q[11:0]};
`ifdef SAT_EN
    if (slice_ovf) begin
      final_res = a_lat_q[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      final_res = final_wrap;
    end
`else
    final_res = final_wrap;
`endif
  end

  // Next-state logic for the controller, operand latches and outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_lat_d   = a_lat_q;
    b_lat_d   = b_lat_q;
    op_d      = op_q;
    chain_c_d = chain_c_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Accept: capture operands, preload carry-in with op
          a_lat_d   = a;
          b_lat_d   = b;
          op_d      = op;
          cnt_d     = 2'd0;
          chain_c_d = op;
          state_d   = ST_RUN;
        end else begin
          // DONE lasts one cycle only
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Intermediate nibble write; start is ignored while running
        result_d[nib_base +: 4] = slice_sum;
        chain_c_d               = slice_cout;
        cnt_d                   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          result_d = final_res;
          carry_d  = slice_cout;
          ovf_d    = slice_ovf;
          zero_d   = (final_res == 16'h0000);
          state_d  = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      a_lat_q   <= 16'h0000;
      b_lat_q   <= 16'h0000;
      op_q      <= 1'b0;
      chain_c_q <= 1'b0;
      result_q  <= 16'h0000;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_lat_q   <= a_lat_d;
      b_lat_q   <= b_lat_d;
      op_q      <= op_d;
      chain_c_q <= chain_c_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Testbench for nibble_serial_alu_ctrl: table of directed vectors plus
// hand-written sequences for back-to-back starts and mid-run reset.
// Honours SAT_EN the same way the design does.

module tb_nibble_serial_alu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res_wrap;
    logic [15:0] res_sat;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  nibble_serial_alu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pick_res(input vec_t v);
`ifdef SAT_EN
    return v.res_sat;
`else
    return v.res_wrap;
`endif
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},   {31'd0, busy},      32'd0);
    check({tag, "_done"},   {31'd0, done},      32'd0);
    check({tag, "_result"}, {16'd0, result},    32'h0000);
    check({tag, "_carry"},  {31'd0, carry_out}, 32'd0);
    check({tag, "_ovf"},    {31'd0, overflow},  32'd0);
    check({tag, "_zero"},   {31'd0, zero},      32'd1);
  endtask

  // One full operation: accept, scramble inputs, wait for done, check all
  task automatic run_op(input vec_t v);
    int          lat;
    bit          got;
    logic [15:0] exp_res;
    exp_res = pick_res(v);
    @(negedge clk);
    start = 1'b1;
    op    = v.op;
    a     = v.a;
    b     = v.b;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~v.a;
    b     = v.a;
    op    = ~v.op;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
      else if (lat < 4) check("busy_run", {31'd0, busy}, 32'd1);
    end
    check("latency",  lat, 4);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("result",   {16'd0, result}, {16'd0, exp_res});
    check("carry",    {31'd0, carry_out}, {31'd0, v.cout});
    check("overflow", {31'd0, overflow},  {31'd0, v.ovf});
    check("zero",     {31'd0, zero},      {31'd0, (exp_res == 16'h0000)});
    $display("op=%0d a=%h b=%h -> result=%h carry=%b ovf=%b zero=%b lat=%0d",
             v.op, v.a, v.b, result, carry_out, overflow, zero, lat);
    @(posedge clk);
    #1;
    check("done_pulse",  {31'd0, done},   32'd0);
    check("result_hold", {16'd0, result}, {16'd0, exp_res});
  endtask

  initial begin
    int lat;
    int dcount;
    bit got;
    vec_t rv;

    //         op    a         b         wrap      sat       cout  ovf
    vecs[0]  = '{1'b1, 16'h1234, 16'h0034, 16'h1200, 16'h1200, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 16'hA5A5, 16'hA5A5, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 16'h5555, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0FFF, 16'h0001, 16'h1000, 16'h1000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op(vecs[i]);

    // Start held through RUN with changed operands, then accepted in DONE
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 16'hA5A5;
    b     = 16'hA5A5;
    @(posedge clk);
    #1;
    op = 1'b0;
    a  = 16'h1111;
    b  = 16'h2222;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    check("b2b_latency1", lat, 4);
    check("b2b_result1", {16'd0, result}, 32'h0000);
    check("b2b_zero1",   {31'd0, zero},      32'd1);
    check("b2b_carry1",  {31'd0, carry_out}, 32'd1);
    $display("b2b first: result=%h carry=%b zero=%b", result, carry_out, zero);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (done) got = 1'b1;
    end
    check("b2b_spacing", lat, 5);
    check("b2b_result2", {16'd0, result}, 32'h3333);
    check("b2b_carry2",  {31'd0, carry_out}, 32'd0);
    check("b2b_ovf2",    {31'd0, overflow},  32'd0);
    check("b2b_zero2",   {31'd0, zero},      32'd0);
    $display("b2b second: result=%h carry=%b zero=%b spacing=%0d", result, carry_out, zero, lat);

    // Reset during the second RUN cycle aborts the operation
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 16'h1234;
    b     = 16'h4321;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    check_reset_values("midrst_after");
    $display("mid-run reset: done pulses=%0d result=%h zero=%b", dcount, result, zero);

    rv = vecs[6];
    run_op(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
NIBBLE_SERIAL_ALU_CTRL -- requirements
Module: nibble_serial_alu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an operation; sampled only when busy=0.
- op  input  1  operation select: 0 = add, 1 = subtract (a-b).
- a  input  16  operand A, two's complement or unsigned.
- b  input  16  operand B.
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when result and flags are valid.
- result  output  16  sum or difference, held until the next accepted start.
- carry_out  output  1  final carry; for subtract, 1 means no borrow (a>=b unsigned).
- overflow  output  1  signed overflow of the 16-bit operation.
- zero  output  1  high when result==16'h0000.

Function
REQ-003 The block SHALL compute the 16-bit operation through one 4-bit add/subtract slice, reused once per cycle for 4 cycles, least-significant nibble first.
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE; RUN SHALL have a 2-bit nibble counter cnt.
REQ-005 In IDLE or DONE with start=1 at a rising edge, the block SHALL latch a, b and op, set cnt=0, load the chain carry with op (1 for subtract, 0 for add), and enter RUN.
REQ-006 During RUN, the slice SHALL take a_lat[4cnt+3:4cnt] and either b_lat[4cnt+3:4cnt] (add) or its bitwise inverse (subtract), with the chain carry as carry-in.
REQ-007 At each RUN edge, the block SHALL write the slice sum to result[4cnt+3:4cnt], store the slice carry-out as the chain carry, and increment cnt.
REQ-008 At the RUN edge where cnt=3, the block SHALL:
- set carry_out to the slice carry-out;
- set overflow to (carry into bit 15) XOR (carry out of bit 15);
- update zero from the final 16-bit result;
- enter DONE.
REQ-009 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE unless REQ-005 applies.
REQ-010 Latency: for start sampled at edge k, done SHALL be high in the cycle after edge k+4, and result and flags SHALL be valid in that same cycle.
REQ-011 busy SHALL be 1 exactly in RUN; start while busy=1 SHALL be ignored and SHALL NOT disturb latched operands.
REQ-012 A start sampled in DONE SHALL be accepted, giving back-to-back operations every 5 cycles with no IDLE cycle.
REQ-013 Changes on a, b or op after the accepting edge SHALL NOT affect the operation in progress.
REQ-014 result, carry_out, overflow and zero SHALL hold their values from the last completed operation until the final RUN edge of the next operation. Intermediate nibble writes to result are permitted and are not guaranteed meaningful while busy=1.

Reset
REQ-015 When rst_n=0, regardless of clk, the block SHALL force:
- state=IDLE and cnt=0;
- busy=0 and done=0;
- result=16'h0000, carry_out=0, overflow=0;
- zero=1;
- latched operands and chain carry to 0.
REQ-016 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-017 Macro SAT_EN SHALL select saturating signed arithmetic.
REQ-018 With SAT_EN defined, at the final RUN edge where overflow=1, result SHALL be written as 16'h8000 if a_lat[15]=1, else 16'h7FFF. overflow SHALL still report 1, and zero SHALL be computed on the saturated value.
REQ-019 Without SAT_EN, result SHALL be the wrapped 16-bit value and no saturation logic SHALL be present.

Verification
REQ-020 op=1, a=16'h1234, b=16'h0034 -> result 16'h1200, carry_out 1, overflow 0, zero 0; done 4 cycles after the start edge.
REQ-021 op=1, a=16'h0000, b=16'h0001 -> result 16'hFFFF, carry_out 0, overflow 0.
REQ-022 op=0, a=16'h7FFF, b=16'h0001 -> overflow 1; result 16'h8000 without SAT_EN, 16'h7FFF with SAT_EN. op=1, a=16'h8000, b=16'h0001 -> overflow 1; result 16'h7FFF without SAT_EN, 16'h8000 with SAT_EN.
REQ-023 op=1, a=b=16'hA5A5 -> result 0, zero 1, carry_out 1. A second start held high during RUN is ignored; a start in the DONE cycle yields a second done exactly 5 cycles after the first.
REQ-024 Drive rst_n low for 1 cycle at the second RUN cycle -> no done pulse, all outputs at reset values. A start 2 cycles later completes with the correct result.
